game_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 26 ++
 rtl/jump_ctrl.sv | 95 +++++++++
 rtl/game_sequencer.sv | 134 +++++++++++++
 tb/tb_game_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the obstacle-game controller.
package game_pkg;

   typedef enum logic [1:0] {
      MENU = 2'd0,
      PLAY = 2'd1,
      WON  = 2'd2,
      LOST = 2'd3
   } game_state_e;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } jump_state_e;

   localparam int DEF_LEVEL_TICKS = 200;
   localparam int DEF_JUMP_HEIGHT = 60;
   localparam int DEF_RISE_STEP   = 4;
   localparam int DEF_FALL_STEP   = 4;
   localparam int DEF_HOLD_TICKS  = 120;

   localparam int DIST_W  = 10;
   localparam int ARITH_W = 11;

endpackage

// File: rtl/jump_ctrl.sv
// Player jump arc: GROUND -> RISE -> FALL -> GROUND, advancing one step per
// game tick while the game is in PLAY. Owns the distance register.
module jump_ctrl
   import game_pkg::*;
#(
   parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
   parameter int RISE_STEP   = DEF_RISE_STEP,
   parameter int FALL_STEP   = DEF_FALL_STEP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       enable,
   input  logic       clear,
   input  logic       jump_edge,
   output logic [9:0] distance,
   output logic       jump_busy
);

   localparam logic [ARITH_W-1:0] PEAK11 = ARITH_W'(JUMP_HEIGHT);
   localparam logic [ARITH_W-1:0] RISE11 = ARITH_W'(RISE_STEP);
   localparam logic [ARITH_W-1:0] FALL11 = ARITH_W'(FALL_STEP);
   localparam logic [DIST_W-1:0]  PEAK10 = PEAK11[10] ? 10'h3FF : PEAK11[9:0];

   jump_state_e       jst_q, jst_d;
   logic [DIST_W-1:0] dist_q, dist_d;

   // Rise step saturated at the peak, then clamped into the 10-bit output range.
   function automatic logic [DIST_W-1:0] rise_sat(input logic [DIST_W-1:0] d);
      logic [ARITH_W-1:0] sum;
      logic [ARITH_W-1:0] lim;
      sum = {1'b0, d} + RISE11;
      lim = (sum >= PEAK11) ? PEAK11 : sum;
      return lim[10] ? 10'h3FF : lim[9:0];
   endfunction

   // Fall step floored at ground level.
   function automatic logic [DIST_W-1:0] fall_sat(input logic [DIST_W-1:0] d);
      logic [ARITH_W-1:0] diff;
      if ({1'b0, d} <= FALL11) begin
         return '0;
      end
      diff = {1'b0, d} - FALL11;
      return diff[9:0];
   endfunction

   // Next jump state and height; a clear or leaving PLAY pins the player to the ground.
   always_comb begin
      jst_d  = jst_q;
      dist_d = dist_q;
      if (clear || (tick && !enable)) begin
         jst_d  = GROUND;
         dist_d = '0;
      end else if (tick) begin
         case (jst_q)
            GROUND: begin
               if (jump_edge) begin
                  jst_d = RISE;
               end
            end
            RISE: begin
               dist_d = rise_sat(dist_q);
               if (dist_d == PEAK10) begin
                  jst_d = FALL;
               end
            end
            FALL: begin
               dist_d = fall_sat(dist_q);
               if (dist_d == '0) begin
                  jst_d = GROUND;
               end
            end
            default: begin
               jst_d  = GROUND;
               dist_d = '0;
            end
         endcase
      end
   end

   // Jump state and height registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jst_q  <= GROUND;
         dist_q <= '0;
      end else begin
         jst_q  <= jst_d;
         dist_q <= dist_d;
      end
   end

   assign distance  = dist_q;
   assign jump_busy = (jst_q == RISE) || (jst_q == FALL);

endmodule

// File: rtl/game_sequencer.sv
// Gameplay controller: MENU / PLAY / WON / LOST phases, level and hold timers,
// win counter and button edge detection. All progress is gated by the game tick.
module game_sequencer
   import game_pkg::*;
#(
   parameter int LEVEL_TICKS = DEF_LEVEL_TICKS,
   parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
   parameter int RISE_STEP   = DEF_RISE_STEP,
   parameter int FALL_STEP   = DEF_FALL_STEP,
   parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_btn,
   input  logic       jump_btn,
   input  logic       collision,
   output logic       menu_screen,
   output logic       player_won,
   output logic       player_lost,
   output logic [9:0] distance,
   output logic       jump_busy,
   output logic [7:0] wins
);

   localparam int LVL_W  = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
   localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LEVEL_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

   game_state_e       state_q, state_d;
   logic [LVL_W-1:0]  level_cnt_q, level_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [7:0]        wins_q, wins_d;
   logic              start_prev_q, start_prev_d;
   logic              jump_prev_q, jump_prev_d;

   logic start_edge;
   logic jump_edge;
   logic jump_enable;
   logic jump_clear;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign start_edge  = tick && start_btn && !start_prev_q;
   assign jump_edge   = tick && jump_btn && !jump_prev_q;
   assign jump_enable = (state_q == PLAY);
   // Any phase change restarts the jump from the ground.
   assign jump_clear  = tick && (state_d != state_q);

   // Main phase sequencing, timers and button history, all advanced on tick only.
   always_comb begin
      state_d      = state_q;
      level_cnt_d  = level_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      wins_d       = wins_q;
      start_prev_d = start_prev_q;
      jump_prev_d  = jump_prev_q;
      if (tick) begin
         start_prev_d = start_btn;
         jump_prev_d  = jump_btn;
         case (state_q)
            MENU: begin
               if (start_edge) begin
                  state_d     = PLAY;
                  level_cnt_d = '0;
               end
            end
            PLAY: begin
               level_cnt_d = level_cnt_q + 1'b1;
               if (collision) begin
                  state_d = LOST;
               end else if (level_cnt_q == LVL_LAST) begin
                  state_d = WON;
                  wins_d  = sat_inc8(wins_q);
               end
            end
            WON, LOST: begin
               if ((hold_cnt_q == HOLD_LAST) || start_edge) begin
                  state_d    = MENU;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = MENU;
            end
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= MENU;
         level_cnt_q  <= '0;
         hold_cnt_q   <= '0;
         wins_q       <= '0;
         start_prev_q <= 1'b0;
         jump_prev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_cnt_q  <= level_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         wins_q       <= wins_d;
         start_prev_q <= start_prev_d;
         jump_prev_q  <= jump_prev_d;
      end
   end

   jump_ctrl #(
      .JUMP_HEIGHT (JUMP_HEIGHT),
      .RISE_STEP   (RISE_STEP),
      .FALL_STEP   (FALL_STEP)
   ) u_jump (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .enable    (jump_enable),
      .clear     (jump_clear),
      .jump_edge (jump_edge),
      .distance  (distance),
      .jump_busy (jump_busy)
   );

   assign menu_screen = (state_q == MENU);
   assign player_won  = (state_q == WON);
   assign player_lost = (state_q == LOST);
   assign wins        = wins_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random play against a
// tick-level behavioural model of the game rules.
module tb_game_sequencer;

   localparam int L = 200;
   localparam int J = 60;
   localparam int R = 4;
   localparam int F = 4;
   localparam int H = 120;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       start_btn;
   logic       jump_btn;
   logic       collision;
   logic       menu_screen;
   logic       player_won;
   logic       player_lost;
   logic [9:0] distance;
   logic       jump_busy;
   logic [7:0] wins;

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .start_btn   (start_btn),
      .jump_btn    (jump_btn),
      .collision   (collision),
      .menu_screen (menu_screen),
      .player_won  (player_won),
      .player_lost (player_lost),
      .distance    (distance),
      .jump_busy   (jump_busy),
      .wins        (wins)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   // Model: mode 0=menu 1=play 2=won 3=lost; the jump is a queue of heights still to fly.
   int m_mode;
   int m_lvl;
   int m_hold;
   int m_wins;
   int m_dist;
   bit m_sprev;
   bit m_jprev;
   int m_arc[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_lvl = 0; m_hold = 0; m_wins = 0; m_dist = 0;
      m_sprev = 0; m_jprev = 0;
      m_arc.delete();
   endfunction

   function automatic void model_ground();
      m_arc.delete();
      m_dist = 0;
   endfunction

   function automatic void model_launch();
      int h;
      h = 0;
      do begin
         h = (h + R > J) ? J : h + R;
         m_arc.push_back(h);
      end while (h != J);
      do begin
         h = (h - F < 0) ? 0 : h - F;
         m_arc.push_back(h);
      end while (h != 0);
   endfunction

   function automatic void model_tick(input bit s, input bit j, input bit c);
      bit se, je;
      se = s && !m_sprev;
      je = j && !m_jprev;
      m_sprev = s;
      m_jprev = j;
      case (m_mode)
         0: if (se) begin m_mode = 1; m_lvl = 0; model_ground(); end
         1: begin
            m_lvl++;
            if (c) begin
               m_mode = 3; model_ground();
            end else if (m_lvl == L) begin
               m_mode = 2; model_ground();
               if (m_wins < 255) m_wins++;
            end else if (m_arc.size() > 0) begin
               m_dist = m_arc.pop_front();
            end else if (je) begin
               model_launch();
            end
         end
         default: begin
            m_hold++;
            if (m_hold == H || se) begin m_mode = 0; m_hold = 0; end
         end
      endcase
   endfunction

   task automatic step(input bit t, input bit s, input bit j, input bit c);
      tick = t; start_btn = s; jump_btn = j; collision = c;
      @(posedge clk);
      if (t && !reset) model_tick(s, j, c);
      #1;
   endtask

   // Compare process: every cycle outside reset, DUT outputs must equal the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && !reset) begin
            check("menu_screen", menu_screen, int'(m_mode == 0));
            check("player_won",  player_won,  int'(m_mode == 2));
            check("player_lost", player_lost, int'(m_mode == 3));
            check("distance",    distance,    m_dist);
            check("jump_busy",   jump_busy,   int'(m_arc.size() > 0));
            check("wins",        wins,        m_wins);
         end
      end
   end

   initial begin
      int guard;
      reset = 1'b1; tick = 0; start_btn = 0; jump_btn = 0; collision = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_menu", menu_screen, 1);
      check("rst_won", player_won, 0);
      check("rst_lost", player_lost, 0);
      check("rst_dist", distance, 0);
      check("rst_busy", jump_busy, 0);
      check("rst_wins", wins, 0);
      reset = 1'b0;
      chk_en = 1;

      // Idle ticks keep the menu up.
      for (int k = 0; k < 10; k++) begin
         step(1, 0, 0, 0);
         check("idle_menu", menu_screen, 1);
      end

      // Full level with no collision, including ticks gapped by idle cycles.
      step(1, 1, 0, 0);
      check("start_menu", menu_screen, 0);
      for (int k = 1; k <= L; k++) begin
         if (k % 37 == 0) step(0, 0, 0, 0);
         step(1, 0, 0, 0);
         if (k == L - 1) check("pre_win", player_won, 0);
      end
      check("win_flag", player_won, 1);
      check("win_count", wins, 1);
      for (int k = 1; k <= H; k++) begin
         step(1, 0, 0, 0);
         if (k == H - 1) check("hold_won", player_won, 1);
      end
      check("hold_menu", menu_screen, 1);
      check("hold_won_off", player_won, 0);

      // One jump arc, button held for 40 ticks.
      step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      check("arc_d0", distance, 0);
      check("arc_b0", jump_busy, 1);
      for (int k = 1; k <= 39; k++) begin
         step(1, 0, 1, 0);
         check("arc_dist", distance, (k <= 15) ? 4 * k : ((k <= 30) ? 60 - 4 * (k - 15) : 0));
         check("arc_busy", jump_busy, (k < 30) ? 1 : 0);
      end
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      check("rejump_busy", jump_busy, 1);

      // Run to the last level tick, jump in flight, collide on the winning tick.
      guard = 0;
      while (m_lvl < L - 1 && guard < 400) begin
         step(1, 0, (m_lvl == 190), 0);
         guard++;
      end
      check("reach_last", m_lvl, L - 1);
      check("pre_col_dist", distance, 32);
      step(1, 0, 0, 1);
      check("col_lost", player_lost, 1);
      check("col_won", player_won, 0);
      check("col_wins", wins, 1);
      check("col_dist", distance, 0);
      repeat (5) step(1, 0, 0, 0);
      check("lost_hold", player_lost, 1);
      step(1, 1, 0, 0);
      check("lost_start_menu", menu_screen, 1);
      check("lost_start_off", player_lost, 0);
      step(1, 0, 0, 0);

      // Asynchronous reset in the middle of a rise.
      step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      repeat (8) step(1, 0, 1, 0);
      check("mid_rise", distance, 32);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("async_dist", distance, 0);
      check("async_menu", menu_screen, 1);
      check("async_busy", jump_busy, 0);
      tick = 0; start_btn = 0; jump_btn = 0; collision = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Random play against the model.
      for (int i = 0; i < 4000; i++) begin
         bit s, j, c, t;
         t = 1'($urandom_range(0, 1));
         s = ($urandom_range(0, 19) == 0) ? !start_btn : start_btn;
         j = ($urandom_range(0, 5) == 0) ? !jump_btn : jump_btn;
         c = ($urandom_range(0, 149) == 0);
         if (i == 2000) begin
            reset = 1'b1;
            model_reset();
            tick = 0; start_btn = 0; jump_btn = 0; collision = 0;
            @(posedge clk);
            #1;
            reset = 1'b0;
         end
         step(t, s, j, c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
